jtag_csr_bank: RTL



---
 rtl/jtag_pkg.sv | 24 ++
 rtl/jtag_csr_bank_if.sv | 26 ++
 rtl/jtag_csr_satcnt.sv | 24 ++
 rtl/jtag_csr_bank.sv | 127 ++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG CSR bank: register map, bit positions, ID.
// Optional autoincrement is controlled by JTAG_CSR_AUTOINC_EN (see top).
package jtag_pkg;

    localparam logic [2:0] CSR_ID_A     = 3'd0;
    localparam logic [2:0] CSR_CTRL_A   = 3'd1;
    localparam logic [2:0] CSR_SCR0_A   = 3'd2;
    localparam logic [2:0] CSR_SCR1_A   = 3'd3;
    localparam logic [2:0] CSR_CNT_A    = 3'd4;
    localparam logic [2:0] CSR_STATUS_A = 3'd5;
    localparam logic [2:0] CSR_TCKCNT_A = 3'd6;
    localparam logic [2:0] CSR_RSVD_A   = 3'd7;

    localparam logic [31:0] CSR_ID_DEFAULT = 32'h4A54_4147;

    localparam int CTRL_AUTOINC_B = 0;
    localparam int STATUS_ERR_B   = 0;

    // Writes to these addresses are flagged as errors.
    function automatic logic csr_is_ro(input logic [2:0] a);
        return a inside {CSR_ID_A, CSR_CNT_A, CSR_TCKCNT_A, CSR_RSVD_A};
    endfunction

endpackage

// File: rtl/jtag_csr_bank_if.sv
// DR-side update pulses in, pointer/read data/control out.
// master = JTAG DR side, slave = CSR bank.
interface jtag_csr_bank_if;

    logic        dr_csr_addr_valid;
    logic [2:0]  dr_csr_addr;
    logic        dr_csr_data_valid;
    logic [31:0] dr_csr_data;
    logic [3:0]  dbg_fsm;
    logic [2:0]  csr_addr;
    logic [31:0] csr_data;
    logic [31:0] ctrl;

    modport master (
        output dr_csr_addr_valid, dr_csr_addr,
        output dr_csr_data_valid, dr_csr_data, dbg_fsm,
        input  csr_addr, csr_data, ctrl
    );

    modport slave (
        input  dr_csr_addr_valid, dr_csr_addr,
        input  dr_csr_data_valid, dr_csr_data, dbg_fsm,
        output csr_addr, csr_data, ctrl
    );

endinterface

// File: rtl/jtag_csr_satcnt.sv
// Saturating up-counter with increment enable.
// Holds at all-ones instead of wrapping.
module jtag_csr_satcnt #(
    parameter int W = 16
) (
    input  logic         tck,
    input  logic         trst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/jtag_csr_bank.sv
// Eight-entry 32-bit CSR bank closing the JTAG DR CSR loop.
// `define JTAG_CSR_AUTOINC_EN to make CTRL[0] enable pointer autoincrement.
module jtag_csr_bank
    import jtag_pkg::*;
#(
    parameter logic [31:0] CSR_ID   = CSR_ID_DEFAULT,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic            tck,
    input  logic            trst_n,
    jtag_csr_bank_if.slave  bus
);

`ifdef JTAG_CSR_AUTOINC_EN
    localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CTRL_MASK = ~(32'd1 << CTRL_AUTOINC_B);
`endif

    logic [2:0]  r_ptr;
    logic [31:0] r_ctrl;
    logic [31:0] r_scr0;
    logic [31:0] r_scr1;
    logic        r_err;
    logic [3:0]  r_fsm;
    logic [31:0] r_tckcnt;
    logic [31:0] r_rdata;

    logic        w_wr;
    logic        w_bad;
    logic        w_clr;
    logic [15:0] w_wr_cnt;
    logic [15:0] w_err_cnt;
    logic [31:0] w_status;
    logic [31:0] w_rd;

    assign w_wr  = bus.dr_csr_data_valid;
    assign w_bad = w_wr & csr_is_ro(r_ptr);
    assign w_clr = w_wr & (r_ptr == CSR_STATUS_A)
                 & bus.dr_csr_data[STATUS_ERR_B];

    jtag_csr_satcnt #(.W(16)) u_wr_cnt (
        .tck    (tck),
        .trst_n (trst_n),
        .i_inc  (w_wr),
        .o_cnt  (w_wr_cnt)
    );

    jtag_csr_satcnt #(.W(16)) u_err_cnt (
        .tck    (tck),
        .trst_n (trst_n),
        .i_inc  (w_bad),
        .o_cnt  (w_err_cnt)
    );

    // A same-cycle pointer load overrides autoincrement.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ptr <= CSR_ID_A;
        end else if (bus.dr_csr_addr_valid) begin
            r_ptr <= bus.dr_csr_addr;
`ifdef JTAG_CSR_AUTOINC_EN
        end else if (w_wr && r_ctrl[CTRL_AUTOINC_B]) begin
            r_ptr <= r_ptr + 3'd1;
`endif
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ctrl <= CTRL_RST & CTRL_MASK;
            r_scr0 <= '0;
            r_scr1 <= '0;
        end else if (w_wr) begin
            if (r_ptr == CSR_CTRL_A) r_ctrl <= bus.dr_csr_data & CTRL_MASK;
            if (r_ptr == CSR_SCR0_A) r_scr0 <= bus.dr_csr_data;
            if (r_ptr == CSR_SCR1_A) r_scr1 <= bus.dr_csr_data;
        end
    end

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_err <= 1'b0;
            r_fsm <= '0;
        end else begin
            if (w_bad) r_err <= 1'b1;
            else if (w_clr) r_err <= 1'b0;
            if (w_wr) r_fsm <= bus.dbg_fsm;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) r_tckcnt <= '0;
        else r_tckcnt <= r_tckcnt + 32'd1;
    end

    always_comb begin
        w_status = '0;
        w_status[STATUS_ERR_B] = r_err;
        w_status[7:4] = r_fsm;
    end

    always_comb begin
        w_rd = '0;
        case (r_ptr)
            CSR_ID_A:     w_rd = CSR_ID;
            CSR_CTRL_A:   w_rd = r_ctrl;
            CSR_SCR0_A:   w_rd = r_scr0;
            CSR_SCR1_A:   w_rd = r_scr1;
            CSR_CNT_A:    w_rd = {w_err_cnt, w_wr_cnt};
            CSR_STATUS_A: w_rd = w_status;
            CSR_TCKCNT_A: w_rd = r_tckcnt;
            default:      w_rd = '0;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) r_rdata <= '0;
        else r_rdata <= w_rd;
    end

    assign bus.csr_addr = r_ptr;
    assign bus.csr_data = r_rdata;
    assign bus.ctrl     = r_ctrl;

endmodule
